// File: rtl/athena_dip_bridge.sv
// Athena DIP settings receiver: captures the host-written DIP word, holds it pending until vblank
// or timeout, then commits it as the active word and serves it to the game CPU and back to the host.
module athena_dip_bridge #(
    parameter logic [31:0] BRIDGE_ADDR  = 32'h0020_0000,
    parameter logic [15:0] DEFAULT_WORD = 16'h9E32,
    parameter logic [23:0] TIMEOUT      = 24'd2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    input  logic        vblank,
    input  logic        cpu_dip_sel,
    output logic [7:0]  cpu_dip_data,
    output logic [15:0] dip_word,
    output logic        cabinet,
    output logic        lives,
    output logic        freeze,
    output logic        demo_sounds,
    output logic        energy,
    output logic [1:0]  coin_a,
    output logic [1:0]  coin_b,
    output logic [1:0]  difficulty,
    output logic [2:0]  bonus_life,
    output logic        dip_changed,
    output logic        flip_changed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] active;
    logic [15:0] pending;
    logic        pending_valid;
    logic [23:0] timer;
    logic        vblank_d;
    logic        addr_hit;
    logic        wr_hit;
    logic        rd_hit;
    logic        trigger;

    assign addr_hit = (bridge_addr == BRIDGE_ADDR);
    assign wr_hit   = bridge_wr && addr_hit;
    assign rd_hit   = bridge_rd && addr_hit;
    assign trigger  = (state == PEND) &&
                      ((vblank && !vblank_d) || (timer == TIMEOUT - 24'd1));

    assign dip_word    = active;
    assign energy      = active[15];
    assign bonus_life  = {active[13:12], active[2]};
    assign freeze      = active[11];
    assign demo_sounds = active[10];
    assign difficulty  = active[9:8];
    assign coin_b      = active[7:6];
    assign coin_a      = active[5:4];
    assign lives       = active[3];
    assign cabinet     = active[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            active         <= DEFAULT_WORD;
            pending        <= 16'h0000;
            pending_valid  <= 1'b0;
            timer          <= 24'd0;
            vblank_d       <= 1'b0;
            bridge_rd_data <= 32'h0;
            cpu_dip_data   <= 8'h00;
            dip_changed    <= 1'b0;
            flip_changed   <= 1'b0;
        end else begin
            vblank_d       <= vblank;
            dip_changed    <= 1'b0;
            flip_changed   <= 1'b0;
            // Reads see the registers as they were before any same-cycle write or commit.
            bridge_rd_data <= rd_hit ? {pending_valid, 15'b0, active} : 32'h0;
            cpu_dip_data   <= cpu_dip_sel ? active[15:8] : active[7:0];

            if (trigger) begin
                active        <= pending;
                dip_changed   <= 1'b1;
                flip_changed  <= pending[1] ^ active[1];
                pending_valid <= 1'b0;
                state         <= COMMIT;
            end else if (state == PEND) begin
                timer <= timer + 24'd1;
            end else if (state == COMMIT) begin
                state <= IDLE;
            end

            // A write wins over the commit bookkeeping above: it becomes the new pending word.
            if (wr_hit) begin
                pending       <= bridge_wr_data[15:0] & 16'hBFFE;
                pending_valid <= 1'b1;
                timer         <= 24'd0;
                state         <= PEND;
            end
        end
    end

endmodule
